keypad_bcd_encoder: RTL and testbench
=====================================

Name: keypad_bcd_encoder

Overview:
- Decimal-keypad-to-BCD encoder; the inverse direction of the team's BCD-to-decimal decoder.
- Accepts ten active-high key lines, one per digit 0..9, from a keypad or switch bank.
- Synchronizes and debounces the key lines, then encodes a single pressed key to 4-bit BCD.
- Delivers each key press exactly once over a valid/ready handshake to downstream logic, e.g. a display or accumulator.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a press is accepted; legal range 1..255.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- key  input  10  asynchronous key lines; key[d]=1 means digit d is pressed.
- ready  input  1  consumer accepts bcd when ready=1 and valid=1 in the same cycle.
- bcd  output  4  BCD code of the accepted key, 0000..1001; stable while valid=1.
- valid  output  1  a press is being offered.
- err  output  1  registered; 1 when the synchronized key vector has two or more bits set.
- press_cnt  output  8  count of completed transfers; wraps 255 to 0.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; sync flops, captured pattern and debounce counter cleared.
  - bcd=0, valid=0, err=0, press_cnt=0.
  - Reset overrides everything in any state, including mid-debounce and while valid=1; the pending press is discarded.
- Synchronizer:
  - Two flops per key line; key_s is the second stage.
  - The FSM only ever looks at key_s.
- err:
  - err <= (number of ones in key_s >= 2), every cycle, in every state.
- State IDLE:
  - key_s one-hot: capture pat=key_s, cnt=0, go to DEBOUNCE.
  - key_s zero or multi-hot: stay in IDLE.
- State DEBOUNCE:
  - key_s != pat (release, bounce, or extra key): go to IDLE, no output.
  - key_s == pat and cnt == DEBOUNCE_CYCLES-1: load bcd with the index of pat, go to VALID.
  - Otherwise: cnt <= cnt+1.
  - cnt is 8 bits wide.
- State VALID:
  - valid=1; bcd held constant.
  - ready=1: transfer; press_cnt <= press_cnt+1 (mod 256); go to RELEASE.
  - ready may be low indefinitely; key changes are ignored here, so releasing the key does not cancel the offer.
- State RELEASE:
  - valid=0.
  - Leave for IDLE only after one cycle with key_s == 0.
  - A held key never repeats. A new key pressed without releasing the first is not accepted.
- Latency:
  - Counted from the rising edge that first samples a stable key to valid=1: DEBOUNCE_CYCLES+3 edges.
  - Breakdown: 2 sync edges, 1 IDLE to DEBOUNCE edge, DEBOUNCE_CYCLES counting edges.
  - Minimum 4 edges, at DEBOUNCE_CYCLES=1.
- Handshake:
  - valid deasserts on the edge after the transfer cycle.
  - At most one transfer per press.
  - A transfer can happen in the first valid cycle if ready is already 1.
- Outputs:
  - bcd keeps its last value after the transfer until the next load.
  - All outputs are registered; no combinational path from key or ready to any output.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then key=10'b0000001000 held, ready=1 -> valid=1 with bcd=0011 at the 7th edge after key applied; valid high for exactly 1 cycle; press_cnt=1; no second valid while the key is held.
- key=digit 9 held, ready=0 for 20 cycles, key released at cycle 12, ready=1 at cycle 20 -> bcd=1001, valid stays high through cycle 20, transfer occurs, press_cnt increments once.
- Bounce: key[5] toggles 1,0,1,0 every 2 cycles, then held stable -> no valid during bouncing; exactly one valid with bcd=0101 after stable for 4 synchronized samples.
- key=10'b0000100010 (digits 1 and 5 together) -> err=1 from the 3rd edge onward, valid never asserts; drop to digit 1 only -> err=0, then valid with bcd=0001.
- Sweep digits 0..9 with release between presses, repeated 26 times (260 presses), ready=1 -> bcd matches each digit; press_cnt wraps 255 -> 0 and ends at 4.
- rst=1 asserted while valid=1 (or mid-DEBOUNCE) -> next cycle valid=0, bcd=0, press_cnt=0, err=0; the held key is re-debounced from IDLE after rst drops.

Source files
------------

// File: rtl/keypad_bcd_encoder.sv
// Decimal keypad to BCD encoder: two-flop synchronizer, debounce FSM and a
// valid/ready handshake that delivers each key press exactly once.
module keypad_bcd_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key,
  input  logic       ready,
  output logic [3:0] bcd,
  output logic       valid,
  output logic       err,
  output logic [7:0] press_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_VALID    = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [9:0] r_sync1;
  logic [9:0] r_sync2;
  logic [9:0] r_pat;
  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_press_cnt;
  logic [3:0] r_bcd;
  logic       r_valid;
  logic       r_err;

  logic [3:0] w_ones;
  logic       w_onehot;
  logic       w_multi;
  logic [3:0] w_pat_idx;

  always_comb begin
    w_ones    = '0;
    w_pat_idx = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      w_ones = w_ones + {3'b000, r_sync2[i]};
      if (r_pat[i]) w_pat_idx = 4'(i);
    end
    w_onehot = (w_ones == 4'd1);
    w_multi  = (w_ones >= 4'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_pat       <= '0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_press_cnt <= '0;
      r_bcd       <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
      r_err   <= w_multi;
      case (r_state)
        S_IDLE: begin
          if (w_onehot) begin
            r_pat   <= r_sync2;
            r_cnt   <= '0;
            r_state <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          // Any deviation from the captured pattern restarts the debounce.
          if (r_sync2 != r_pat) begin
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_bcd   <= w_pat_idx;
            r_valid <= 1'b1;
            r_state <= S_VALID;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_VALID: begin
          if (ready) begin
            r_valid     <= 1'b0;
            r_press_cnt <= r_press_cnt + 8'd1;
            r_state     <= S_RELEASE;
          end
        end
        default: begin
          if (r_sync2 == '0) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bcd       = r_bcd;
  assign valid     = r_valid;
  assign err       = r_err;
  assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Bench for keypad_bcd_encoder: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_keypad_bcd_encoder;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] key;
  logic       ready;
  logic [3:0] bcd;
  logic       valid;
  logic       err;
  logic [7:0] press_cnt;

  keypad_bcd_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .key(key), .ready(ready),
    .bcd(bcd), .valid(valid), .err(err), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Behavioural model: key_s is the key input delayed by two edges; a press is
  // offered once a one-hot pattern has been seen for D+1 consecutive samples
  // while waiting, and a new run can only start on the sample after a break.
  logic [9:0] m_s1 = '0, m_s2 = '0, m_pat = '0;
  int         m_run = 0, m_phase = 0, m_cnt = 0;
  logic       m_valid = 1'b0, m_err = 1'b0;
  logic [3:0] m_bcd = '0;
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    logic [9:0] ks;
    ks = m_s2;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_pat = '0;
      m_run = 0; m_phase = 0; m_cnt = 0;
      m_valid = 1'b0; m_err = 1'b0; m_bcd = '0;
      m_live = 1'b1;
    end else begin
      m_err = ($countones(ks) >= 2);
      if (m_phase == 0) begin
        if (m_run == 0) begin
          if ($onehot(ks)) begin m_pat = ks; m_run = 1; end
        end else if (ks != m_pat) begin
          m_run = 0;
        end else if (m_run == D) begin
          m_phase = 1; m_valid = 1'b1; m_bcd = 4'(digit_of(ks));
        end else begin
          m_run++;
        end
      end else if (m_phase == 1) begin
        if (ready) begin
          m_cnt = (m_cnt + 1) % 256; m_valid = 1'b0; m_phase = 2;
        end
      end else begin
        if (ks == '0) begin m_phase = 0; m_run = 0; end
      end
      m_s2 = m_s1;
      m_s1 = key;
    end
    #1;
    if (m_live) begin
      chk("model_valid", valid, m_valid);
      chk("model_bcd", bcd, m_bcd);
      chk("model_err", err, m_err);
      chk("model_press_cnt", press_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid && n < maxc);
    if (!valid) chk("valid_timeout", valid, 1);
  endtask

  task automatic count_valid(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (valid) c++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  int lat, cnt;

  initial begin
    rst = 1'b1; key = '0; ready = 1'b0;
    ticks(2);
    chk("rst_valid", valid, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_err", err, 0);
    chk("rst_press_cnt", press_cnt, 0);
    rst = 1'b0;
    ticks(3);

    // Digit 3 held with ready=1
    key = 10'b0000001000; ready = 1'b1;
    wait_valid(20, lat);
    chk("d3_latency", lat, 7);
    chk("d3_bcd", bcd, 3);
    tick();
    chk("d3_one_cycle", valid, 0);
    chk("d3_press_cnt", press_cnt, 1);
    count_valid(12, cnt);
    chk("d3_no_repeat", cnt, 0);
    key = '0;
    ticks(4);

    // Digit 9 with ready low for a long time, key released meanwhile
    key = 10'b1000000000; ready = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (i == 12) key = '0;
    end
    chk("d9_valid_held", valid, 1);
    chk("d9_bcd", bcd, 9);
    ready = 1'b1;
    tick();
    chk("d9_after_xfer", valid, 0);
    chk("d9_press_cnt", press_cnt, 2);
    ticks(4);

    // Bounce on digit 5
    for (int b = 0; b < 4; b++) begin
      key = (b % 2 == 0) ? 10'b0000100000 : 10'b0;
      for (int j = 0; j < 2; j++) begin
        tick();
        if (valid) chk("bounce_no_valid", valid, 0);
      end
    end
    key = 10'b0000100000;
    wait_valid(20, lat);
    chk("bounce_latency", lat, 7);
    chk("bounce_bcd", bcd, 5);
    count_valid(10, cnt);
    chk("bounce_single", cnt, 0);
    chk("bounce_press_cnt", press_cnt, 3);
    key = '0;
    ticks(4);

    // Digits 1 and 5 together, then only digit 1
    key = 10'b0000100010;
    ticks(2);
    chk("multi_err_edge2", err, 0);
    tick();
    chk("multi_err_edge3", err, 1);
    count_valid(12, cnt);
    chk("multi_no_valid", cnt, 0);
    key = 10'b0000000010;
    wait_valid(20, lat);
    chk("multi_to_one_latency", lat, 7);
    chk("multi_to_one_err", err, 0);
    chk("multi_to_one_bcd", bcd, 1);
    tick();
    chk("multi_press_cnt", press_cnt, 4);
    key = '0;
    ticks(4);

    // Reset while valid, then re-debounce of the held key
    ready = 1'b0;
    key = 10'b0010000000;
    wait_valid(20, lat);
    chk("r7_latency", lat, 7);
    rst = 1'b1;
    tick();
    chk("rstv_valid", valid, 0);
    chk("rstv_bcd", bcd, 0);
    chk("rstv_press_cnt", press_cnt, 0);
    chk("rstv_err", err, 0);
    rst = 1'b0;
    wait_valid(20, lat);
    chk("rstv_redebounce_latency", lat, 7);
    chk("rstv_redebounce_bcd", bcd, 7);
    ready = 1'b1;
    tick();
    chk("rstv_press_cnt_after", press_cnt, 1);
    key = '0;
    ticks(4);

    // Reset mid-debounce discards the press
    key = 10'b0000000100;
    ticks(4);
    rst = 1'b1;
    tick();
    chk("rstd_press_cnt", press_cnt, 0);
    rst = 1'b0;
    key = '0;
    count_valid(10, cnt);
    chk("rstd_no_valid", cnt, 0);

    // Sweep 260 presses
    do_reset();
    ready = 1'b1;
    for (int r = 0; r < 26; r++) begin
      for (int d = 0; d < 10; d++) begin
        key = 10'(1 << d);
        wait_valid(20, lat);
        chk("sweep_bcd", bcd, d);
        tick();
        key = '0;
        ticks(4);
        if (r == 25 && d == 5) chk("sweep_wrap", press_cnt, 0);
      end
    end
    chk("sweep_final_cnt", press_cnt, 4);

    // Randomized traffic; the model is checked on every cycle
    for (int n = 0; n < 250; n++) begin
      int sel, hold;
      sel = $urandom_range(0, 9);
      if (sel < 2) key = '0;
      else if (sel < 8) key = 10'(1 << $urandom_range(0, 9));
      else if (sel == 8) key = 10'(1 << $urandom_range(0, 9)) | 10'(1 << $urandom_range(0, 9));
      else key = 10'($urandom);
      hold = $urandom_range(1, 14);
      for (int h = 0; h < hold; h++) begin
        ready = ($urandom_range(0, 2) != 0);
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
